// File: rtl/buyruk_getir_birimi.sv
// Instruction fetch unit: owns the PC, reads combinational instruction memory and
// buffers fetched words in a small FIFO toward Decode, with redirect flush and fault capture.
module buyruk_getir_birimi #(
    parameter int unsigned          ADRES_BIT       = 32,
    parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000,
    parameter int unsigned          VERI_BIT        = 32,
    parameter int unsigned          BELLEK_BAYT     = 8192,
    parameter int unsigned          FIFO_DERINLIK   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_veri,
    input  logic                 yonlendir_gecerli,
    input  logic [ADRES_BIT-1:0] yonlendir_adres,
    output logic                 buyruk_gecerli,
    input  logic                 buyruk_hazir,
    output logic [VERI_BIT-1:0]  buyruk,
    output logic [ADRES_BIT-1:0] buyruk_pc,
    output logic                 buyruk_hata
);

    localparam int unsigned          PTR_BIT   = $clog2(FIFO_DERINLIK);
    localparam logic [PTR_BIT:0]     DOLU_SAYI = (PTR_BIT+1)'(FIFO_DERINLIK);
    localparam logic [ADRES_BIT:0]   PENCERE   = (ADRES_BIT+1)'(BELLEK_BAYT);
    localparam logic [ADRES_BIT-1:0] ADIM      = ADRES_BIT'(4);

    typedef enum logic [1:0] {
        BASLAT,
        GETIR,
        HATA_BEKLE
    } durum_t;

    durum_t               durum;
    logic [ADRES_BIT-1:0] pc;
    logic [PTR_BIT-1:0]   oku_ptr;
    logic [PTR_BIT-1:0]   yaz_ptr;
    logic [PTR_BIT:0]     sayac;

    logic [ADRES_BIT-1:0]     fifo_pc   [FIFO_DERINLIK];
    logic [VERI_BIT-1:0]      fifo_veri [FIFO_DERINLIK];
    logic [FIFO_DERINLIK-1:0] fifo_hata;

    logic                 bos;
    logic                 dolu;
    logic                 cek;
    logic                 atesle;
    logic                 pencere_ici;
    logic                 hatali;
    logic [ADRES_BIT:0]   pc_genis;
    logic [ADRES_BIT:0]   pc_fark;

    // Window test one bit wider than the address so neither compare nor subtract can overflow
    assign pc_genis    = {1'b0, pc};
    assign pc_fark     = pc_genis - {1'b0, BASLANGIC_ADRES};
    assign pencere_ici = (pc_genis >= {1'b0, BASLANGIC_ADRES}) && (pc_fark < PENCERE);
    assign hatali      = (pc[1:0] != 2'b00) || !pencere_ici;

    assign bos    = (sayac == '0);
    assign dolu   = (sayac == DOLU_SAYI);
    assign cek    = buyruk_gecerli && buyruk_hazir;
    assign atesle = (durum == GETIR) && !yonlendir_gecerli && (!dolu || cek);

    assign bellek_adres   = pc;
    assign buyruk_gecerli = !bos && !yonlendir_gecerli;
    assign buyruk         = buyruk_gecerli ? fifo_veri[oku_ptr] : '0;
    assign buyruk_pc      = buyruk_gecerli ? fifo_pc[oku_ptr]   : '0;
    assign buyruk_hata    = buyruk_gecerli ? fifo_hata[oku_ptr] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum   <= BASLAT;
            pc      <= BASLANGIC_ADRES;
            oku_ptr <= '0;
            yaz_ptr <= '0;
            sayac   <= '0;
        end else if (yonlendir_gecerli) begin
            pc      <= yonlendir_adres;
            oku_ptr <= '0;
            yaz_ptr <= '0;
            sayac   <= '0;
            durum   <= GETIR;
        end else begin
            if (cek)
                oku_ptr <= oku_ptr + PTR_BIT'(1);
            if (atesle)
                yaz_ptr <= yaz_ptr + PTR_BIT'(1);
            case ({atesle, cek})
                2'b10:   sayac <= sayac + (PTR_BIT+1)'(1);
                2'b01:   sayac <= sayac - (PTR_BIT+1)'(1);
                default: ;
            endcase
            case (durum)
                BASLAT: durum <= GETIR;
                GETIR: begin
                    if (atesle) begin
                        if (hatali)
                            durum <= HATA_BEKLE;
                        else
                            pc <= pc + ADIM;
                    end
                end
                HATA_BEKLE: ;
                default: durum <= BASLAT;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the count
    always_ff @(posedge clk) begin
        if (atesle) begin
            fifo_pc[yaz_ptr]   <= pc;
            fifo_veri[yaz_ptr] <= hatali ? '0 : bellek_veri;
            fifo_hata[yaz_ptr] <= hatali;
        end
    end

endmodule

// File: tb/tb_buyruk_getir_birimi.sv
// Self-checking bench for buyruk_getir_birimi: directed table, corner-case sequences
// and randomized redirect/backpressure traffic against a queue-based reference model.
module tb_buyruk_getir_birimi;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned BAYT  = 8192;
    localparam int unsigned DERIN = 2;

    logic        clk;
    logic        rst;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_veri;
    logic        yonlendir_gecerli;
    logic [31:0] yonlendir_adres;
    logic        buyruk_gecerli;
    logic        buyruk_hazir;
    logic [31:0] buyruk;
    logic [31:0] buyruk_pc;
    logic        buyruk_hata;

    buyruk_getir_birimi #(
        .ADRES_BIT(32),
        .BASLANGIC_ADRES(BASE),
        .VERI_BIT(32),
        .BELLEK_BAYT(BAYT),
        .FIFO_DERINLIK(DERIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bellek_adres(bellek_adres),
        .bellek_veri(bellek_veri),
        .yonlendir_gecerli(yonlendir_gecerli),
        .yonlendir_adres(yonlendir_adres),
        .buyruk_gecerli(buyruk_gecerli),
        .buyruk_hazir(buyruk_hazir),
        .buyruk(buyruk),
        .buyruk_pc(buyruk_pc),
        .buyruk_hata(buyruk_hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        if (a == 32'h8000_0004) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always_comb bellek_veri = memf(bellek_adres);

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of buffered entries, next fetch address, fetch mode
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
        logic        h;
    } ent_t;

    localparam int M_START = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          mmode;

    function automatic bit kusurlu(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || ((a - BASE) >= BAYT);
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc   = BASE;
        mmode = M_START;
    endtask

    task automatic apply(input logic yon, input logic [31:0] adr, input logic hz);
        bit ev;
        yonlendir_gecerli = yon;
        yonlendir_adres   = adr;
        buyruk_hazir      = hz;
        #1;
        ev = (mq.size() > 0) && !yon;
        chk("adres", bellek_adres, mpc);
        chk("gecerli", {31'b0, buyruk_gecerli}, {31'b0, ev});
        if (ev) begin
            chk("pc", buyruk_pc, mq[0].pc);
            chk("buyruk", buyruk, mq[0].w);
            chk("hata", {31'b0, buyruk_hata}, {31'b0, mq[0].h});
        end else begin
            chk("pc_bos", buyruk_pc, 32'h0);
            chk("buyruk_bos", buyruk, 32'h0);
            chk("hata_bos", {31'b0, buyruk_hata}, 32'h0);
        end
    endtask

    task automatic advance();
        bit   pop;
        bit   fire;
        ent_t e;
        if (yonlendir_gecerli) begin
            mq.delete();
            mpc   = yonlendir_adres;
            mmode = M_FETCH;
        end else begin
            pop  = (mq.size() > 0) && buyruk_hazir;
            fire = (mmode == M_FETCH) && ((mq.size() < DERIN) || pop);
            if (pop) void'(mq.pop_front());
            if (fire) begin
                if (kusurlu(mpc)) begin
                    e = '{mpc, 32'h0, 1'b1};
                    mmode = M_HALT;
                end else begin
                    e = '{mpc, memf(mpc), 1'b0};
                    mpc = mpc + 32'd4;
                end
                mq.push_back(e);
            end
            if (mmode == M_START) mmode = M_FETCH;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        yon;
        logic [31:0] adr;
        logic        hz;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ew;
        logic [31:0] eadr;
    } vek_t;

    vek_t tablo[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        tablo[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h8000_0000};
        tablo[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h8000_0000};
        tablo[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 32'h8000_0004};
        tablo[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 32'h8000_0008};
        tablo[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 32'h8000_0008};
        tablo[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0013, 32'h8000_0008};
        tablo[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0004, 32'h0010_0093, 32'h8000_000C};
        tablo[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0008, memf(32'h8000_0008), 32'h8000_0010};

        rst = 1'b1;
        yonlendir_gecerli = 1'b0;
        yonlendir_adres   = 32'h0;
        buyruk_hazir      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_gecerli", {31'b0, buyruk_gecerli}, 32'h0);
        chk("rst_buyruk", buyruk, 32'h0);
        chk("rst_pc", buyruk_pc, 32'h0);
        chk("rst_hata", {31'b0, buyruk_hata}, 32'h0);
        chk("rst_adres", bellek_adres, BASE);
        rst = 1'b0;

        // Startup latency, backpressure buffering, in-order drain
        for (int i = 0; i < 8; i++) begin
            apply(tablo[i].yon, tablo[i].adr, tablo[i].hz);
            chk("tab_gecerli", {31'b0, buyruk_gecerli}, {31'b0, tablo[i].ev});
            chk("tab_adres", bellek_adres, tablo[i].eadr);
            if (tablo[i].ev) begin
                chk("tab_pc", buyruk_pc, tablo[i].epc);
                chk("tab_buyruk", buyruk, tablo[i].ew);
            end
            advance();
        end

        // Redirect with full FIFO
        apply(1'b0, 32'h0, 1'b0);
        advance();
        apply(1'b1, 32'h8000_0100, 1'b0);
        chk("t3_maske", {31'b0, buyruk_gecerli}, 32'h0);
        advance();
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            apply(1'b0, 32'h0, 1'b1);
            if (buyruk_gecerli) begin
                found = 1'b1;
                chk("t3_pc", buyruk_pc, 32'h8000_0100);
                chk("t3_buyruk", buyruk, memf(32'h8000_0100));
            end
            advance();
        end
        if (!found) chk("t3_zaman", 32'h0, 32'h1);

        // Redirect coinciding with full+pop: no pop, flush, target next
        apply(1'b0, 32'h0, 1'b0);
        advance();
        apply(1'b0, 32'h0, 1'b0);
        advance();
        apply(1'b1, 32'h8000_0200, 1'b1);
        chk("t7_maske", {31'b0, buyruk_gecerli}, 32'h0);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t7_bos", {31'b0, buyruk_gecerli}, 32'h0);
        chk("t7_adres", bellek_adres, 32'h8000_0200);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t7_pc", buyruk_pc, 32'h8000_0200);
        advance();

        // Misaligned redirect target
        apply(1'b1, 32'h8000_0102, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t4_adres", bellek_adres, 32'h8000_0102);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t4_gecerli", {31'b0, buyruk_gecerli}, 32'h1);
        chk("t4_pc", buyruk_pc, 32'h8000_0102);
        chk("t4_hata", {31'b0, buyruk_hata}, 32'h1);
        chk("t4_buyruk", buyruk, 32'h0);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, 1'b1);
            chk("t4_sessiz", {31'b0, buyruk_gecerli}, 32'h0);
            chk("t4_tut", bellek_adres, 32'h8000_0102);
            advance();
        end
        apply(1'b1, 32'h8000_0000, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t4_devam", buyruk_pc, 32'h8000_0000);
        advance();

        // Run off the top of the window
        apply(1'b1, 32'h8000_1FF0, 1'b1);
        advance();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply(1'b0, 32'h0, 1'b1);
            if (buyruk_gecerli && buyruk_hata) begin
                found = 1'b1;
                chk("t5_pc", buyruk_pc, 32'h8000_2000);
            end
            advance();
        end
        if (!found) chk("t5_zaman", 32'h0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b1);
            chk("t5_adres", bellek_adres, 32'h8000_2000);
            chk("t5_sessiz", {31'b0, buyruk_gecerli}, 32'h0);
            advance();
        end

        // Async reset with two entries buffered
        apply(1'b1, 32'h8000_0040, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b0);
            advance();
        end
        chk("t6_dolu", {31'b0, buyruk_gecerli}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_gecerli", {31'b0, buyruk_gecerli}, 32'h0);
        chk("t6_adres", bellek_adres, BASE);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 32'h0, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        advance();
        apply(1'b0, 32'h0, 1'b1);
        chk("t6_gecerli2", {31'b0, buyruk_gecerli}, 32'h1);
        chk("t6_pc", buyruk_pc, 32'h8000_0000);
        advance();

        // Randomized backpressure and redirects
        for (int i = 0; i < 3000; i++) begin
            logic        yon;
            logic [31:0] adr;
            int          r;
            yon = ($urandom_range(0, 99) < ((mmode == M_HALT) ? 30 : 6));
            r = $urandom_range(0, 9);
            case (r)
                6:       adr = BASE + BAYT - 32'd4 * $urandom_range(1, 4);
                7:       adr = BASE + {$urandom_range(0, 2047), 2'b01};
                8:       adr = 32'h7FFF_FFFC;
                9:       adr = 32'hFFFF_FFFC;
                default: adr = BASE + 32'd4 * $urandom_range(0, 2047);
            endcase
            apply(yon, adr, ($urandom_range(0, 99) < 75));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
